// File: rtl/motor_input_cond.sv
// motor_input_cond: synchronises, debounces and conditions the push-button
// and both limit switches feeding the motor up/down controller.
// Optional build macro: MOTOR_COND_HOLDOFF_EN adds a post-press holdoff window
// during which further button presses are ignored.
module motor_input_cond #(
   parameter int unsigned DEBOUNCE = 16,
   parameter int unsigned CNT_W    = 5,
   parameter int unsigned HOLDOFF  = 1000,
   parameter int unsigned HOLD_W   = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   input  logic up_lim_raw,
   input  logic dn_lim_raw,
   input  logic fault_clr,
   output logic activate,
   output logic up_limit,
   output logic dn_limit,
   output logic fault
);

   // Channel indices into the per-input vectors below.
   localparam int unsigned CH_BTN = 0;
   localparam int unsigned CH_UP  = 1;
   localparam int unsigned CH_DN  = 2;
   localparam int unsigned N_CH   = 3;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

   logic [N_CH-1:0]  raw;
   logic [N_CH-1:0]  s1;
   logic [N_CH-1:0]  s2;
   logic [N_CH-1:0]  stable;
   logic [N_CH-1:0]  accept;
   logic [CNT_W-1:0] cnt [N_CH];

   logic btn_rise;
   logic fault_set;
   logic hold_clear;
   logic fire;

   assign raw = {dn_lim_raw, up_lim_raw, btn_raw};

   // Two-flop synchroniser for every raw input.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= raw;
         s2 <= s1;
      end
   end

   // A channel flips its stable level once the differing synced value has
   // held for DEBOUNCE consecutive cycles.
   always_comb begin
      accept = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         accept[i] = (s2[i] != stable[i]) && (cnt[i] == CNT_MAX);
      end
   end

   // Per-channel debounce counter and accepted stable level.
   always_ff @(posedge clk) begin
      if (rst) begin
         stable <= '0;
         for (int unsigned i = 0; i < N_CH; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < N_CH; i++) begin
            if (s2[i] == stable[i]) begin
               cnt[i] <= '0;
            end else if (accept[i]) begin
               stable[i] <= s2[i];
               cnt[i]    <= '0;
            end else begin
               cnt[i] <= cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   assign btn_rise  = accept[CH_BTN] & s2[CH_BTN];
   assign fault_set = stable[CH_UP] & stable[CH_DN];

`ifdef MOTOR_COND_HOLDOFF_EN
   logic [HOLD_W-1:0] hold_cnt;

   assign hold_clear = (hold_cnt == '0);

   // Holdoff window: reloads on every pulse, counts down to idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_cnt <= '0;
      end else if (fire) begin
         hold_cnt <= HOLD_W'(HOLDOFF - 1);
      end else if (hold_cnt != '0) begin
         hold_cnt <= hold_cnt - HOLD_W'(1);
      end
   end
`else
   logic unused_hold_params;

   assign hold_clear         = 1'b1;
   assign unused_hold_params = ^{HOLDOFF, HOLD_W};
`endif

   // A press fires only when no fault is present or being raised this edge.
   always_comb begin
      fire = btn_rise & hold_clear & ~fault & ~fault_set;
   end

   // Registered activate pulse and sticky fault flag; set beats clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         activate <= 1'b0;
         fault    <= 1'b0;
      end else begin
         activate <= fire;
         if (fault_set) begin
            fault <= 1'b1;
         end else if (fault_clr) begin
            fault <= 1'b0;
         end
      end
   end

   assign up_limit = stable[CH_UP];
   assign dn_limit = stable[CH_DN];

endmodule

// File: tb/tb_motor_input_cond.sv
// tb_motor_input_cond: directed checks of motor_input_cond with DEBOUNCE=4.
// Edge numbering: tick 1 is the first posedge that samples a changed input.
module tb_motor_input_cond;

   logic clk = 1'b0;
   logic rst;
   logic btn_raw;
   logic up_lim_raw;
   logic dn_lim_raw;
   logic fault_clr;
   logic activate;
   logic up_limit;
   logic dn_limit;
   logic fault;

   int checks   = 0;
   int failures = 0;
   int pulses;

   typedef struct {
      logic        rst;
      logic        btn;
      logic        up;
      logic        dn;
      logic        clr;
      int unsigned n;
      logic        e_act;
      logic        e_up;
      logic        e_dn;
      logic        e_fault;
   } vec_t;

   localparam int NV = 13;
   vec_t vecs [NV];

   motor_input_cond #(
      .DEBOUNCE(4),
      .CNT_W   (3),
      .HOLDOFF (50),
      .HOLD_W  (6)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_raw   (btn_raw),
      .up_lim_raw(up_lim_raw),
      .dn_lim_raw(dn_lim_raw),
      .fault_clr (fault_clr),
      .activate  (activate),
      .up_limit  (up_limit),
      .dn_limit  (dn_limit),
      .fault     (fault)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%b expected=%b", name, got, exp);
      end
   endtask

   task automatic chk_int(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", name, got, exp);
      end
   endtask

   initial begin
      rst        = 1'b1;
      btn_raw    = 1'b0;
      up_lim_raw = 1'b0;
      dn_lim_raw = 1'b0;
      fault_clr  = 1'b0;

      //            rst   btn   up    dn    clr   n   act   up    dn    fault
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2,  1'b0, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3,  1'b0, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8,  1'b0, 1'b1, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8,  1'b0, 1'b0, 1'b1, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8,  1'b0, 1'b1, 1'b1, 1'b1};
      vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1,  1'b0, 1'b1, 1'b1, 1'b1};
      vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8,  1'b0, 1'b0, 1'b1, 1'b1};
      vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1,  1'b0, 1'b0, 1'b1, 1'b0};
      vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8,  1'b0, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5,  1'b0, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1,  1'b1, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1,  1'b0, 1'b0, 1'b0, 1'b0};
      vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10, 1'b0, 1'b0, 1'b0, 1'b0};

      for (int v = 0; v < NV; v++) begin
         rst        = vecs[v].rst;
         btn_raw    = vecs[v].btn;
         up_lim_raw = vecs[v].up;
         dn_lim_raw = vecs[v].dn;
         fault_clr  = vecs[v].clr;
         for (int unsigned k = 0; k < vecs[v].n; k++) tick();
         chk($sformatf("vec%0d_activate", v), activate, vecs[v].e_act);
         chk($sformatf("vec%0d_up_limit", v), up_limit, vecs[v].e_up);
         chk($sformatf("vec%0d_dn_limit", v), dn_limit, vecs[v].e_dn);
         chk($sformatf("vec%0d_fault", v),    fault,    vecs[v].e_fault);
      end

      // Clean press: exactly one pulse, on tick 6; none on release.
      btn_raw = 1'b1;
      pulses  = 0;
      for (int t = 1; t <= 20; t++) begin
         tick();
         if (activate) pulses++;
         if (t == 6) chk("press_tick6", activate, 1'b1);
      end
      chk_int("press_pulses", pulses, 1);
      btn_raw = 1'b0;
      pulses  = 0;
      for (int t = 1; t <= 20; t++) begin
         tick();
         if (activate) pulses++;
      end
      chk_int("release_pulses", pulses, 0);

      // Bounce on the upper limit: 1,0,1,0 then held 1; rises at tick 10.
      up_lim_raw = 1'b1;
      for (int t = 1; t <= 12; t++) begin
         tick();
         chk($sformatf("bounce_t%0d", t), up_limit, (t >= 10));
         if (t < 4) up_lim_raw = (t % 2 == 0);
         else       up_lim_raw = 1'b1;
      end
      chk("bounce_dn_quiet", dn_limit, 1'b0);

      // Fault raised on tick 7; button settling on that same edge must not fire.
      dn_lim_raw = 1'b1;
      pulses     = 0;
      for (int t = 1; t <= 10; t++) begin
         tick();
         if (activate) pulses++;
         if (t == 6) chk("fault_t6", fault, 1'b0);
         if (t == 7) chk("fault_t7", fault, 1'b1);
         if (t == 1) btn_raw = 1'b1;
      end
      chk_int("coincident_pulses", pulses, 0);

      fault_clr = 1'b1;
      tick();
      fault_clr = 1'b0;
      chk("clr_blocked", fault, 1'b1);

      btn_raw = 1'b0;
      repeat (8) tick();
      btn_raw = 1'b1;
      pulses  = 0;
      for (int t = 1; t <= 10; t++) begin
         tick();
         if (activate) pulses++;
      end
      chk_int("press_in_fault", pulses, 0);
      chk("fault_held", fault, 1'b1);

      btn_raw    = 1'b0;
      dn_lim_raw = 1'b0;
      repeat (8) tick();
      chk("drop_dn_limit", dn_limit, 1'b0);
      chk("drop_up_limit", up_limit, 1'b1);
      chk("drop_fault", fault, 1'b1);

      fault_clr = 1'b1;
      tick();
      chk("clr_fault", fault, 1'b0);
      fault_clr = 1'b0;
      tick();
      chk("clr_fault_stays", fault, 1'b0);
      chk("clr_no_activate", activate, 1'b0);

      // Reset mid-count: partial count discarded, pulse 6 ticks after release.
      btn_raw = 1'b1;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      chk("rst_activate", activate, 1'b0);
      chk("rst_up_limit", up_limit, 1'b0);
      chk("rst_dn_limit", dn_limit, 1'b0);
      chk("rst_fault", fault, 1'b0);
      rst = 1'b0;
      for (int t = 1; t <= 6; t++) begin
         tick();
         if (t == 5) chk("rst_press_t5", activate, 1'b0);
         if (t == 6) begin
            chk("rst_press_t6", activate, 1'b1);
            chk("rst_up_back", up_limit, 1'b1);
         end
      end

      // Re-press inside / after the holdoff window.
      btn_raw = 1'b0;
      repeat (70) tick();
      btn_raw = 1'b1;
      repeat (6) tick();
      chk("hold_first_press", activate, 1'b1);
      btn_raw = 1'b0;
      repeat (8) tick();
      btn_raw = 1'b1;
      pulses  = 0;
      for (int t = 1; t <= 20; t++) begin
         tick();
         if (activate) pulses++;
      end
`ifdef MOTOR_COND_HOLDOFF_EN
      chk_int("hold_early_repress", pulses, 0);
`else
      chk_int("hold_early_repress", pulses, 1);
`endif
      btn_raw = 1'b0;
      repeat (50) tick();
      btn_raw = 1'b1;
      repeat (6) tick();
      chk("hold_late_repress", activate, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
